display_scan_controller: RTL
============================

# display_scan_controller

Sequencer for the 8-digit multiplexed 7-segment display. Debounces the two front-panel mode switches, selects which two of the four 16-bit counter/TDC values are shown, snapshots them once per frame so digits never tear, and time-multiplexes the eight anodes with a blanking gap between digits to suppress ghosting. Sits between the counter/TDC datapath and the board display pins.

## Interface
- DIGIT_TICKS, 100000: cycles each digit is lit (1 ms at 100 MHz)
- BLANK_TICKS, 1000: cycles all anodes are off before each digit
- DEBOUNCE_TICKS, 1000000: cycles a raw switch level must be stable to be accepted
- AUTOCYCLE_FRAMES, 250: frames per mode step in auto-cycle (see Configuration)

- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- sw_left  in  1  raw switch, asynchronous to clk (TDC select)
- sw_right  in  1  raw switch, asynchronous to clk (coincidence select)
- digits_A  in  16  first counter value
- digits_B  in  16  second counter value
- digits_C  in  16  coincidence counter value
- digits_D  in  16  TDC value
- segments  out  7  active-low segments, bit0=a … bit6=g
- anodes  out  8  active-low digit enables, anodes[0]=rightmost
- mode  out  2  effective display mode of the current frame
- frame_start  out  1  one-cycle pulse on the first cycle of each frame

## Operation
- Switch path: 2-flop synchronizer per switch; debounced level updates only after the synchronized level differs from it for DEBOUNCE_TICKS consecutive cycles; any bounce restarts the count.
- Mode = {sw_left_db, sw_right_db}: 0 → A on digits 7..4, B on 3..0; 1 → C on 3..0, 7..4 blank; 2 → D on 3..0, 7..4 blank; 3 → D on 7..4, C on 3..0.
- Blank digit: anode off for its whole slot (both BLANK and ON phases).
- Snapshot: at each frame boundary, register effective mode and the two selected 16-bit values; the whole frame displays only the snapshot.
- Scan FSM states: BLANK (anodes=8'hFF, segments=7'h7F, BLANK_TICKS cycles) → ON (anodes drives digit index low, segments = hex of nibble, DIGIT_TICKS cycles) → BLANK of next index. After ON of index 7: index wraps to 0, snapshot reloads, frame_start pulses.
- Nibble for index i: bits [4(i mod 4)+3 : 4(i mod 4)] of the value assigned to that half.
- Hex encoding (active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- Switch change mid-frame: no effect until next frame boundary.

## Timing
- Reset values: segments=7'h7F, anodes=8'hFF, mode=0, frame_start=0; FSM in BLANK, index 0, tick counter 0, snapshot 0, debounced switches 0.
- First frame_start: first cycle after reset release; snapshot loaded on that same edge.
- Frame length: 8×(BLANK_TICKS+DIGIT_TICKS) cycles exactly; frame_start period identical.
- All outputs registered; segments and anodes change on the same edge.
- Switch-to-display latency: 2 sync + DEBOUNCE_TICKS + up to one frame.
- Reset asserted mid-frame: outputs go to reset values immediately (async), scan restarts at index 0.

## Configuration
- DISPLAY_AUTOCYCLE_EN defined: while debounced switches are 00, effective mode steps 0→1→2→3→0 every AUTOCYCLE_FRAMES frames, advancing only at frame boundaries; leaving 00 forces mode = switches at next boundary and clears the frame counter; returning to 00 restarts at mode 0.
- Not defined: effective mode = debounced switches; no frame counter logic.

## Structure
- Shared package display_pkg: mode encoding constants, scan state enum, 16-entry hex-to-segment constant table, blank pattern 7'h7F.
- Sub-module switch_debouncer (synchronizer + stability counter, parameter DEBOUNCE_TICKS), instantiated once per switch.

## Test plan
- Bench parameters DIGIT_TICKS=4, BLANK_TICKS=1, DEBOUNCE_TICKS=8, AUTOCYCLE_FRAMES=2.
- Reset, A=16'h1234, B=16'hABCD, switches 00 → anodes walk 0xFE…0x7F with 0xFF gaps; segments per index: D(0x21),C(0x46),b(0x03),A(0x08),4(0x19),3(0x30),2(0x24),1(0x79); frame_start every 40 cycles.
- sw_right bounces high for 5 cycles then stable → no mode change during bounce; mode=1 from the frame after stability; digits 7..4 dark, 3..0 show C.
- Change digits_A mid-frame → current frame unchanged, new value from next frame_start.
- sw_left=sw_right=1, C=16'h0000, D=16'hFFFF → digits 7..4 segments 0x0E, 3..0 0x40.
- With DISPLAY_AUTOCYCLE_EN, switches 00 → mode 0,0,1,1,2,2,3,3,0 across frames; rst_n low mid-ON → anodes=8'hFF same cycle, mode=0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared mode encodings, scan states and 7-segment tables for the display scan controller.
package display_pkg;
  localparam logic [1:0] MODE_AB = 2'd0;
  localparam logic [1:0] MODE_C  = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_DC = 2'd3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  typedef enum logic {ST_BLANK, ST_ON} scan_state_e;
  // active-low a..g patterns, entry 15 (F) first so HEX_SEG[n] is digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer plus stability counter; the output follows the
// synchronized level only after it has differed for DEBOUNCE_TICKS consecutive cycles.
module switch_debouncer #(
  parameter int DEBOUNCE_TICKS = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic sw_o
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic db_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      db_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      if (sync_q[1] == db_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        cnt_q <= '0;
        db_q <= sync_q[1];
      end else cnt_q <= cnt_q + 1'b1;
    end
  assign sw_o = db_q;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: debounced mode select, per-frame snapshot and blank-gapped
// 8-digit anode scan. Define DISPLAY_AUTOCYCLE_EN to auto-step the mode while switches are 00.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000,
  parameter int DEBOUNCE_TICKS = 1000000
`ifdef DISPLAY_AUTOCYCLE_EN
  , parameter int AUTOCYCLE_FRAMES = 250
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_left,
  input  logic        sw_right,
  input  logic [15:0] digits_A,
  input  logic [15:0] digits_B,
  input  logic [15:0] digits_C,
  input  logic [15:0] digits_D,
  output logic [6:0]  segments,
  output logic [7:0]  anodes,
  output logic [1:0]  mode,
  output logic        frame_start
);
  localparam int TW = $clog2((DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS) + 1);
  localparam logic [TW-1:0] DIGIT_END = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS - 1);
  logic sw_left_db, sw_right_db;
  logic [1:0] sw_mode, eff_mode;
  scan_state_e state_q;
  logic [2:0] idx_q;
  logic [TW-1:0] tick_q;
  logic start_q, boundary, hi_lit, lit;
  logic [1:0] mode_q;
  logic [15:0] hi_q, lo_q, hi_d, lo_d, cur_val;
  logic [3:0] nib;
  logic [6:0] segments_q;
  logic [7:0] anodes_q;
  logic frame_start_q;
  switch_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_left (
    .clk(clk), .rst_n(rst_n), .sw_i(sw_left), .sw_o(sw_left_db)
  );
  switch_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_right (
    .clk(clk), .rst_n(rst_n), .sw_i(sw_right), .sw_o(sw_right_db)
  );
  assign sw_mode = {sw_left_db, sw_right_db};
`ifdef DISPLAY_AUTOCYCLE_EN
  localparam int FW = $clog2(AUTOCYCLE_FRAMES + 1);
  logic [1:0] auto_q;
  logic [FW-1:0] fcnt_q;
  assign eff_mode = sw_mode == MODE_AB ? auto_q : sw_mode;
  // any non-zero switch setting parks the cycler so a return to 00 starts over at mode 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      auto_q <= MODE_AB;
      fcnt_q <= '0;
    end else if (boundary) begin
      if (sw_mode != MODE_AB) begin
        auto_q <= MODE_AB;
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(AUTOCYCLE_FRAMES - 1)) begin
        auto_q <= auto_q + 1'b1;
        fcnt_q <= '0;
      end else fcnt_q <= fcnt_q + 1'b1;
    end
`else
  assign eff_mode = sw_mode;
`endif
  // start_q makes the first cycle out of reset behave like an end-of-frame
  assign boundary = start_q || (state_q == ST_ON && idx_q == 3'd7 && tick_q == DIGIT_END);
  assign hi_d = eff_mode == MODE_AB ? digits_A : digits_D;
  assign lo_d = eff_mode == MODE_AB ? digits_B : eff_mode == MODE_D ? digits_D : digits_C;
  assign hi_lit = mode_q == MODE_AB || mode_q == MODE_DC;
  assign cur_val = idx_q[2] ? hi_q : lo_q;
  assign nib = cur_val[{idx_q[1:0], 2'b00} +: 4];
  assign lit = !idx_q[2] || hi_lit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_BLANK;
      idx_q <= '0;
      tick_q <= '0;
      start_q <= 1'b1;
      mode_q <= MODE_AB;
      hi_q <= '0;
      lo_q <= '0;
      segments_q <= SEG_BLANK;
      anodes_q <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      tick_q <= tick_q + 1'b1;
      if (boundary) begin
        start_q <= 1'b0;
        state_q <= ST_BLANK;
        idx_q <= '0;
        tick_q <= '0;
        frame_start_q <= 1'b1;
        mode_q <= eff_mode;
        hi_q <= hi_d;
        lo_q <= lo_d;
        segments_q <= SEG_BLANK;
        anodes_q <= AN_OFF;
      end else if (state_q == ST_BLANK && tick_q == BLANK_END) begin
        state_q <= ST_ON;
        tick_q <= '0;
        segments_q <= lit ? HEX_SEG[nib] : SEG_BLANK;
        anodes_q <= lit ? ~(8'h01 << idx_q) : AN_OFF;
      end else if (state_q == ST_ON && tick_q == DIGIT_END) begin
        state_q <= ST_BLANK;
        tick_q <= '0;
        idx_q <= idx_q + 1'b1;
        segments_q <= SEG_BLANK;
        anodes_q <= AN_OFF;
      end
    end
  assign segments = segments_q;
  assign anodes = anodes_q;
  assign mode = mode_q;
  assign frame_start = frame_start_q;
endmodule
